// File: rtl/uart_spi_bridge_if.sv
// SPI bus bundle for uart_spi_bridge.
// Signals:
//   spi_clk   SPI clock (idle level set by the bridge's Cpol parameter)
//   spi_mosi  data from the bridge to the device, MSB first
//   spi_csb   active-low chip select
//   spi_miso  data from the device (only when UART_SPI_MISO_EN is defined)
// Modports: master = bridge side, slave = device side.
interface uart_spi_bridge_if;
  logic spi_clk;
  logic spi_mosi;
  logic spi_csb;
`ifdef UART_SPI_MISO_EN
  logic spi_miso;
  modport master (output spi_clk, output spi_mosi, output spi_csb, input spi_miso);
  modport slave  (input spi_clk, input spi_mosi, input spi_csb, output spi_miso);
`else
  modport master (output spi_clk, output spi_mosi, output spi_csb);
  modport slave  (input spi_clk, input spi_mosi, input spi_csb);
`endif
endinterface

// File: rtl/uart_spi_bridge.sv
// UART-to-SPI loader bridge: receives 8N1 UART bytes, assembles them into
// DataWidth-bit words, queues the words in a FIFO and replays each word as one
// SPI master transfer (MSB first).
// Ports:
//   clk_i        system clock
//   rst_i        synchronous active-high reset
//   rx_i         UART RX (asynchronous, idle high)
//   lsb_i        1: first byte -> word[7:0]; 0: first byte -> word MSB byte
//   spi          SPI bus (uart_spi_bridge_if.master)
//   fifo_full_o  FIFO holds FifoDepth words
//   busy_o       SPI FSM active or FIFO non-empty
//   overflow_o   sticky, a word was dropped on a full FIFO
//   frame_err_o  one-cycle pulse on a bad stop bit
//   rdata_o      last word read back on MISO (UART_SPI_MISO_EN only)
//   rvalid_o     one-cycle pulse when rdata_o updates (UART_SPI_MISO_EN only)
// Optional feature macro: UART_SPI_MISO_EN adds MISO capture and read-back.
//
// UART FSM
//   state   | meaning
//   U_IDLE  | waiting for falling edge on synchronised rx
//   U_START | waiting to mid start bit, rejects glitches
//   U_DATA  | sampling 8 data bits LSB first at mid-bit
//   U_STOP  | sampling stop bit, good byte or frame error
// SPI FSM
//   state   | meaning
//   S_IDLE  | csb high, pops a word once the csb-high gap has elapsed
//   S_SETUP | csb low, MSB on mosi, SpiDiv cycles before first edge
//   S_SHIFT | DataWidth leading/trailing sclk half-periods
//   S_HOLD  | csb still low SpiDiv cycles after last trailing edge
module uart_spi_bridge #(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned ClocksPerBit = 217,
  parameter int unsigned FifoDepth    = 4,
  parameter int unsigned SpiDiv       = 1,
  parameter bit          Cpol         = 1'b0,
  parameter int unsigned TimeoutClks  = 4096
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               rx_i,
  input  logic               lsb_i,
  uart_spi_bridge_if.master  spi,
  output logic               fifo_full_o,
  output logic               busy_o,
  output logic               overflow_o,
  output logic               frame_err_o
`ifdef UART_SPI_MISO_EN
  ,
  output logic [DataWidth-1:0] rdata_o,
  output logic                 rvalid_o
`endif
);
  localparam int unsigned NumBytes = DataWidth / 8;
  localparam int unsigned BcW      = (NumBytes > 1) ? $clog2(NumBytes) : 1;
  localparam int unsigned CbW      = $clog2(ClocksPerBit);
  localparam int unsigned AddrW    = $clog2(FifoDepth);
  localparam int unsigned DivW     = (SpiDiv > 1) ? $clog2(SpiDiv) : 1;
  localparam int unsigned BitW     = $clog2(DataWidth);
  localparam int unsigned ToW      = $clog2(TimeoutClks + 1);
  localparam logic [BcW-1:0] LastByte = BcW'(NumBytes - 1);

  // ---------------- UART receiver ----------------
  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_e;
  uart_state_e    u_state_q, u_state_d;
  logic           rx_s1_q, rx_s2_q, rx_s3_q;
  logic [CbW-1:0] u_cnt_q, u_cnt_d;
  logic [2:0]     u_bit_q, u_bit_d;
  logic [7:0]     u_byte_q, u_byte_d;
  logic           byte_ok, frame_err, frame_err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_s3_q     <= 1'b1;
      u_state_q   <= U_IDLE;
      u_cnt_q     <= '0;
      u_bit_q     <= '0;
      u_byte_q    <= '0;
      frame_err_q <= 1'b0;
    end else begin
      rx_s1_q     <= rx_i;
      rx_s2_q     <= rx_s1_q;
      rx_s3_q     <= rx_s2_q;
      u_state_q   <= u_state_d;
      u_cnt_q     <= u_cnt_d;
      u_bit_q     <= u_bit_d;
      u_byte_q    <= u_byte_d;
      frame_err_q <= frame_err;
    end
  end

  always_comb begin
    u_state_d = u_state_q;
    u_cnt_d   = u_cnt_q - 1'b1;
    u_bit_d   = u_bit_q;
    u_byte_d  = u_byte_q;
    byte_ok   = 1'b0;
    frame_err = 1'b0;
    unique case (u_state_q)
      U_IDLE: begin
        u_cnt_d = CbW'(ClocksPerBit / 2 - 1);
        if (rx_s3_q && !rx_s2_q) u_state_d = U_START;
      end
      U_START: if (u_cnt_q == '0) begin
        u_cnt_d   = CbW'(ClocksPerBit - 1);
        u_bit_d   = '0;
        u_state_d = rx_s2_q ? U_IDLE : U_DATA;
      end
      U_DATA: if (u_cnt_q == '0) begin
        u_cnt_d  = CbW'(ClocksPerBit - 1);
        u_byte_d = {rx_s2_q, u_byte_q[7:1]};
        u_bit_d  = u_bit_q + 1'b1;
        if (u_bit_q == 3'd7) u_state_d = U_STOP;
      end
      U_STOP: if (u_cnt_q == '0) begin
        u_state_d = U_IDLE;
        byte_ok   = rx_s2_q;
        frame_err = !rx_s2_q;
      end
      default: u_state_d = U_IDLE;
    endcase
  end

  // ---------------- word assembly + partial-word timeout ----------------
  logic [BcW-1:0]       byte_cnt_q, msb_idx;
  logic [DataWidth-1:0] word_q, word_next;
  logic [ToW-1:0]       to_cnt_q;
  logic                 word_done;

  assign msb_idx   = LastByte - byte_cnt_q;
  assign word_done = byte_ok && (byte_cnt_q == LastByte);

  always_comb begin
    word_next = word_q;
    if (lsb_i) word_next[{byte_cnt_q, 3'b000} +: 8] = u_byte_q;
    else       word_next[{msb_idx, 3'b000} +: 8]    = u_byte_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      byte_cnt_q <= '0;
      word_q     <= '0;
      to_cnt_q   <= '0;
    end else if (byte_ok) begin
      word_q     <= word_next;
      byte_cnt_q <= word_done ? '0 : byte_cnt_q + 1'b1;
      to_cnt_q   <= ToW'(TimeoutClks - 1);
    end else if (byte_cnt_q != '0) begin
      if (to_cnt_q == '0) byte_cnt_q <= '0;
      else                to_cnt_q   <= to_cnt_q - 1'b1;
    end
  end

  // ---------------- word FIFO ----------------
  logic [DataWidth-1:0] fifo_mem [FifoDepth];
  logic [AddrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]       count_q;
  logic                 push, pop, overflow_q;

  assign fifo_full_o = (count_q == (AddrW + 1)'(FifoDepth));
  // a full FIFO still accepts a word when the SPI side pops in the same cycle
  assign push = word_done && (!fifo_full_o || pop);

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= word_next;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
      if (word_done && !push) overflow_q <= 1'b1;
    end
  end

  // ---------------- SPI master ----------------
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD} spi_state_e;
  spi_state_e           s_state_q, s_state_d;
  logic [DivW-1:0]      div_q, div_d, gap_q, gap_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic [DataWidth-1:0] sh_q, sh_d;
  logic                 sclk_q, sclk_d, csb_q, csb_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s_state_q <= S_IDLE;
      div_q     <= '0;
      gap_q     <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      sclk_q    <= Cpol;
      csb_q     <= 1'b1;
    end else begin
      s_state_q <= s_state_d;
      div_q     <= div_d;
      gap_q     <= gap_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      sclk_q    <= sclk_d;
      csb_q     <= csb_d;
    end
  end

  always_comb begin
    s_state_d = s_state_q;
    div_d     = (div_q != '0) ? div_q - 1'b1 : div_q;
    gap_d     = (gap_q != '0) ? gap_q - 1'b1 : gap_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    sclk_d    = sclk_q;
    csb_d     = csb_q;
    pop       = 1'b0;
    unique case (s_state_q)
      S_IDLE: if (gap_q == '0 && count_q != '0) begin
        pop       = 1'b1;
        sh_d      = fifo_mem[rd_ptr_q];
        csb_d     = 1'b0;
        sclk_d    = Cpol;
        div_d     = DivW'(SpiDiv - 1);
        bit_d     = '0;
        s_state_d = S_SETUP;
      end
      S_SETUP: if (div_q == '0) begin
        sclk_d    = ~Cpol;
        div_d     = DivW'(SpiDiv - 1);
        s_state_d = S_SHIFT;
      end
      S_SHIFT: if (div_q == '0) begin
        div_d = DivW'(SpiDiv - 1);
        if (sclk_q != Cpol) begin
          sclk_d = Cpol;
          sh_d   = sh_q << 1;
        end else if (bit_q == BitW'(DataWidth - 1)) begin
          s_state_d = S_HOLD;
        end else begin
          sclk_d = ~Cpol;
          bit_d  = bit_q + 1'b1;
        end
      end
      S_HOLD: if (div_q == '0) begin
        csb_d     = 1'b1;
        gap_d     = DivW'(SpiDiv - 1);
        s_state_d = S_IDLE;
      end
      default: s_state_d = S_IDLE;
    endcase
  end

  assign spi.spi_clk  = sclk_q;
  assign spi.spi_csb  = csb_q;
  assign spi.spi_mosi = sh_q[DataWidth-1];
  assign busy_o       = (s_state_q != S_IDLE) || (count_q != '0);
  assign overflow_o   = overflow_q;
  assign frame_err_o  = frame_err_q;

`ifdef UART_SPI_MISO_EN
  logic [DataWidth-1:0] rx_sh_q, rdata_q;
  logic                 rvalid_q, sample, done;

  // MISO is captured at the same clock that launches each leading sclk edge
  assign sample = (sclk_d != Cpol) && (sclk_q == Cpol);
  assign done   = (s_state_q == S_SHIFT) && (s_state_d == S_HOLD);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_sh_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= done;
      if (sample) rx_sh_q <= {rx_sh_q[DataWidth-2:0], spi.spi_miso};
      if (done)   rdata_q <= rx_sh_q;
    end
  end

  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;
`endif
endmodule

// File: tb/tb_uart_spi_bridge.sv
module tb_uart_spi_bridge;
  localparam int Cpb = 8;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic lsb_i = 1'b1;
  logic rx0 = 1'b1;
  logic rx2 = 1'b1;
  always #5 clk_i = ~clk_i;

  logic full0, busy0, ovf0, fe0;
  logic full1, busy1, ovf1, fe1;
  logic full2, busy2, ovf2, fe2;

  uart_spi_bridge_if if0 ();
  uart_spi_bridge_if if1 ();
  uart_spi_bridge_if if2 ();

`ifdef UART_SPI_MISO_EN
  logic [31:0] rdata0, rdata1, rdata2;
  logic        rvalid0, rvalid1, rvalid2;
  assign if0.spi_miso = if0.spi_mosi;
  assign if1.spi_miso = if1.spi_mosi;
  assign if2.spi_miso = if2.spi_mosi;
`endif

  uart_spi_bridge #(.DataWidth(32), .ClocksPerBit(Cpb), .FifoDepth(4), .SpiDiv(2),
                    .Cpol(1'b0), .TimeoutClks(300)) dut0 (
    .clk_i(clk_i), .rst_i(rst_i), .rx_i(rx0), .lsb_i(lsb_i), .spi(if0),
    .fifo_full_o(full0), .busy_o(busy0), .overflow_o(ovf0), .frame_err_o(fe0)
`ifdef UART_SPI_MISO_EN
    , .rdata_o(rdata0), .rvalid_o(rvalid0)
`endif
  );

  uart_spi_bridge #(.DataWidth(32), .ClocksPerBit(Cpb), .FifoDepth(4), .SpiDiv(2),
                    .Cpol(1'b1), .TimeoutClks(300)) dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .rx_i(rx0), .lsb_i(lsb_i), .spi(if1),
    .fifo_full_o(full1), .busy_o(busy1), .overflow_o(ovf1), .frame_err_o(fe1)
`ifdef UART_SPI_MISO_EN
    , .rdata_o(rdata1), .rvalid_o(rvalid1)
`endif
  );

  uart_spi_bridge #(.DataWidth(32), .ClocksPerBit(Cpb), .FifoDepth(4), .SpiDiv(40),
                    .Cpol(1'b0), .TimeoutClks(300)) dut2 (
    .clk_i(clk_i), .rst_i(rst_i), .rx_i(rx2), .lsb_i(lsb_i), .spi(if2),
    .fifo_full_o(full2), .busy_o(busy2), .overflow_o(ovf2), .frame_err_o(fe2)
`ifdef UART_SPI_MISO_EN
    , .rdata_o(rdata2), .rvalid_o(rvalid2)
`endif
  );

  // ---------------- SPI monitors (one per DUT) ----------------
  logic [2:0] m_csb, m_sclk, m_mosi;
  logic [2:0] mcpol = 3'b010;
  logic [2:0] p_csb = 3'b111;
  logic [2:0] p_sclk = 3'b010;
  assign m_csb  = {if2.spi_csb, if1.spi_csb, if0.spi_csb};
  assign m_sclk = {if2.spi_clk, if1.spi_clk, if0.spi_clk};
  assign m_mosi = {if2.spi_mosi, if1.spi_mosi, if0.spi_mosi};

  logic [31:0] cur_sh [3];
  int          cur_pulses [3];
  int          cur_low [3];
  logic [31:0] cap_word [3][32];
  int          cap_pulses [3][32];
  int          cap_low [3][32];
  int          cap_n [3];
  int          fe_cnt = 0;
  int          rv_cnt = 0;

  always @(negedge clk_i) begin
    for (int k = 0; k < 3; k++) begin
      if (!m_csb[k]) begin
        if (p_csb[k]) begin
          cur_sh[k] = '0;
          cur_pulses[k] = 0;
          cur_low[k] = 0;
        end
        cur_low[k]++;
        if (m_sclk[k] != mcpol[k] && p_sclk[k] == mcpol[k]) begin
          cur_sh[k] = {cur_sh[k][30:0], m_mosi[k]};
          cur_pulses[k]++;
        end
      end else if (!p_csb[k] && cap_n[k] < 32) begin
        cap_word[k][cap_n[k]]   = cur_sh[k];
        cap_pulses[k][cap_n[k]] = cur_pulses[k];
        cap_low[k][cap_n[k]]    = cur_low[k];
        cap_n[k]++;
      end
      p_csb[k]  = m_csb[k];
      p_sclk[k] = m_sclk[k];
    end
    if (fe0) fe_cnt++;
`ifdef UART_SPI_MISO_EN
    if (rvalid0) rv_cnt++;
`endif
  end

  // ---------------- checking helpers ----------------
  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_rx(input int line, input logic v);
    if (line == 0) rx0 = v;
    else           rx2 = v;
  endtask

  task automatic send_byte(input int line, input logic [7:0] b, input logic stop);
    set_rx(line, 1'b0);
    repeat (Cpb) @(posedge clk_i);
    for (int i = 0; i < 8; i++) begin
      set_rx(line, b[i]);
      repeat (Cpb) @(posedge clk_i);
    end
    set_rx(line, stop);
    repeat (Cpb) @(posedge clk_i);
    set_rx(line, 1'b1);
    repeat (2) @(posedge clk_i);
  endtask

  // seq[7:0] goes out first
  task automatic send_seq(input int line, input logic [31:0] seq);
    for (int i = 0; i < 4; i++) send_byte(line, seq[8*i +: 8], 1'b1);
  endtask

  task automatic wait_cap(input int k, input int target, input int budget, input string name);
    int n;
    n = 0;
    while (cap_n[k] < target && n < budget) begin
      @(posedge clk_i);
      n++;
    end
    check(name, 64'(cap_n[k] >= target), 64'd1);
  endtask

  typedef struct packed {
    logic        lsb;
    logic [31:0] seq;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int b0, b1, b2, fb, rb;
    logic [31:0] ow [6];

    vecs[0] = '{lsb: 1'b1, seq: 32'h1234_5678, exp: 32'h1234_5678};
    vecs[1] = '{lsb: 1'b0, seq: 32'h1234_5678, exp: 32'h7856_3412};
    vecs[2] = '{lsb: 1'b1, seq: 32'hDDCC_BBAA, exp: 32'hDDCC_BBAA};
    vecs[3] = '{lsb: 1'b0, seq: 32'h00FF_8001, exp: 32'h0180_FF00};
    vecs[4] = '{lsb: 1'b0, seq: 32'h8000_0001, exp: 32'h0100_0080};

    // reset values
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_csb", 64'(m_csb), 64'h7);
    check("rst_sclk", 64'(m_sclk), 64'h2);
    check("rst_mosi", 64'(m_mosi), 64'h0);
    check("rst_full_busy", 64'({full0, busy0, full2, busy2}), 64'h0);
    check("rst_ovf_fe", 64'({ovf0, fe0, ovf2, fe2}), 64'h0);
`ifdef UART_SPI_MISO_EN
    check("rst_rdata", 64'(rdata0), 64'h0);
    check("rst_rvalid", 64'(rvalid0), 64'h0);
`endif
    rst_i = 1'b0;
    repeat (5) @(posedge clk_i);

    // table-driven words through dut0 (Cpol=0) and dut1 (Cpol=1)
    for (int v = 0; v < 5; v++) begin
      lsb_i = vecs[v].lsb;
      b0 = cap_n[0];
      b1 = cap_n[1];
      rb = rv_cnt;
      send_seq(0, vecs[v].seq);
      wait_cap(0, b0 + 1, 600, "vec_done0");
      wait_cap(1, b1 + 1, 600, "vec_done1");
      repeat (4) @(posedge clk_i);
      check($sformatf("vec%0d_word0", v), 64'(cap_word[0][b0]), 64'(vecs[v].exp));
      check($sformatf("vec%0d_pulses0", v), 64'(cap_pulses[0][b0]), 64'd32);
      check($sformatf("vec%0d_csblow0", v), 64'(cap_low[0][b0]), 64'd132);
      check($sformatf("vec%0d_word1", v), 64'(cap_word[1][b1]), 64'(vecs[v].exp));
      check($sformatf("vec%0d_pulses1", v), 64'(cap_pulses[1][b1]), 64'd32);
      check($sformatf("vec%0d_sclk_idle", v), 64'(m_sclk[1:0]), 64'h2);
`ifdef UART_SPI_MISO_EN
      check($sformatf("vec%0d_rdata", v), 64'(rdata0), 64'(vecs[v].exp));
      check($sformatf("vec%0d_rvalid", v), 64'(rv_cnt - rb), 64'd1);
`endif
    end

    // bad stop bit: one-cycle frame error, byte not counted
    lsb_i = 1'b1;
    fb = fe_cnt;
    b0 = cap_n[0];
    send_byte(0, 8'h55, 1'b0);
    repeat (10) @(posedge clk_i);
    check("frame_err_pulse", 64'(fe_cnt - fb), 64'd1);
    send_seq(0, 32'h1122_3344);
    wait_cap(0, b0 + 1, 600, "frame_done");
    repeat (20) @(posedge clk_i);
    check("frame_word", 64'(cap_word[0][b0]), 64'h1122_3344);
    check("frame_count", 64'(cap_n[0] - b0), 64'd1);

    // 3-cycle glitch is rejected
    fb = fe_cnt;
    b0 = cap_n[0];
    @(posedge clk_i);
    rx0 = 1'b0;
    repeat (3) @(posedge clk_i);
    rx0 = 1'b1;
    repeat (20) @(posedge clk_i);
    send_seq(0, 32'h5A5A_A5A5);
    wait_cap(0, b0 + 1, 600, "glitch_done");
    repeat (20) @(posedge clk_i);
    check("glitch_word", 64'(cap_word[0][b0]), 64'h5A5A_A5A5);
    check("glitch_count", 64'(cap_n[0] - b0), 64'd1);
    check("glitch_no_fe", 64'(fe_cnt - fb), 64'd0);

    // partial word timeout
    b0 = cap_n[0];
    send_byte(0, 8'h11, 1'b1);
    send_byte(0, 8'h22, 1'b1);
    repeat (400) @(posedge clk_i);
    check("timeout_no_xfer", 64'(cap_n[0] - b0), 64'd0);
    send_seq(0, 32'hDDCC_BBAA);
    wait_cap(0, b0 + 1, 600, "timeout_done");
    repeat (200) @(posedge clk_i);
    check("timeout_word", 64'(cap_word[0][b0]), 64'hDDCC_BBAA);
    check("timeout_count", 64'(cap_n[0] - b0), 64'd1);

    // overflow on the slow-SPI instance: 6 words, 5 sent in order
    b2 = cap_n[2];
    for (int k = 0; k < 6; k++) begin
      ow[k] = 32'h1000_0001 * (k + 1);
      send_seq(2, ow[k]);
    end
    repeat (4) @(posedge clk_i);
    check("ovf_set", 64'(ovf2), 64'd1);
    check("ovf_full", 64'(full2), 64'd1);
    check("ovf_other_clear", 64'(ovf0), 64'd0);
    wait_cap(2, b2 + 5, 20000, "ovf_done");
    for (int k = 0; k < 5; k++)
      check($sformatf("ovf_word%0d", k), 64'(cap_word[2][b2 + k]), 64'(ow[k]));
    check("ovf_csblow", 64'(cap_low[2][b2]), 64'd2640);
    repeat (3000) @(posedge clk_i);
    check("ovf_count", 64'(cap_n[2] - b2), 64'd5);
    check("ovf_held", 64'(ovf2), 64'd1);
    check("ovf_idle", 64'(busy2), 64'd0);

    // reset at bit 10 of a transfer
    lsb_i = 1'b1;
    send_seq(0, 32'hCAFE_F00D);
    begin
      int n;
      n = 0;
      while (n < 600) begin
        @(posedge clk_i);
        #1;
        if (!m_csb[0] && cur_pulses[0] == 10) break;
        n++;
      end
      check("rst_reach_bit10", 64'(n < 600), 64'd1);
    end
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check("midrst_csb", 64'(m_csb[1:0]), 64'h3);
    check("midrst_sclk", 64'(m_sclk[1:0]), 64'h2);
    check("midrst_busy_full", 64'({busy0, full0, busy1}), 64'h0);
    check("midrst_ovf_cleared", 64'(ovf2), 64'd0);
    repeat (10) @(posedge clk_i);
    b0 = cap_n[0];
    send_seq(0, 32'h0BAD_BEEF);
    wait_cap(0, b0 + 1, 600, "postrst_done");
    repeat (4) @(posedge clk_i);
    check("postrst_word", 64'(cap_word[0][b0]), 64'h0BAD_BEEF);
    check("postrst_pulses", 64'(cap_pulses[0][b0]), 64'd32);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
